// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline/hazard controller signal bundle
interface hazard_ctrl_if #(
  parameter int CW = 32
);
  logic [4:0]    id_rs1;
  logic [4:0]    id_rs2;
  logic          id_uses_rs1;
  logic          id_uses_rs2;
  logic          id_is_mdu;
  logic [4:0]    ex_rd;
  logic          ex_mem_read;
  logic          ex_branch_taken;
  logic          pc_stall;
  logic          ifid_stall;
  logic          ifid_flush;
  logic          idex_stall;
  logic          idex_flush;
  logic          exmem_flush;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_mdu,
           ex_rd, ex_mem_read, ex_branch_taken,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_mdu,
           ex_rd, ex_mem_read, ex_branch_taken,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / branch / multi-cycle MDU hazard controller
// Stall and flush controls are combinational from state and inputs; counters saturate.
module hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CW      = 32
) (
  input  logic clk,
  input  logic rst_n,
  hazard_ctrl_if.slave hif
);
  typedef enum logic {
    IDLE     = 1'b0,
    MDU_BUSY = 1'b1
  } state_t;

  localparam logic [3:0] BUSY_INIT = 4'(MDU_LAT - 1);

  state_t        state_q, state_d;
  logic [3:0]    busy_q, busy_d;
  logic [CW-1:0] stall_q, flush_q;
  logic          lu_hz;
  logic          pc_stall_c, ifid_stall_c, ifid_flush_c;
  logic          idex_stall_c, idex_flush_c, exmem_flush_c;

  assign lu_hz = hif.ex_mem_read && (hif.ex_rd != 5'd0) &&
                 ((hif.id_uses_rs1 && (hif.id_rs1 == hif.ex_rd)) ||
                  (hif.id_uses_rs2 && (hif.id_rs2 == hif.ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_stall_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_flush_c = 1'b0;
    case (state_q)
      IDLE: begin
        // A taken branch makes the ID instruction wrong-path, so its hazards are moot
        if (hif.ex_branch_taken) begin
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
        end else if (lu_hz) begin
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
          idex_flush_c = 1'b1;
        end else if (hif.id_is_mdu) begin
          state_d = MDU_BUSY;
          busy_d  = BUSY_INIT;
        end
      end
      MDU_BUSY: begin
        pc_stall_c    = 1'b1;
        ifid_stall_c  = 1'b1;
        idex_stall_c  = 1'b1;
        exmem_flush_c = 1'b1;
        busy_d        = busy_q - 4'd1;
        if (busy_q == 4'd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign hif.pc_stall    = rst_n & pc_stall_c;
  assign hif.ifid_stall  = rst_n & ifid_stall_c;
  assign hif.ifid_flush  = rst_n & ifid_flush_c;
  assign hif.idex_stall  = rst_n & idex_stall_c;
  assign hif.idex_flush  = rst_n & idex_flush_c;
  assign hif.exmem_flush = rst_n & exmem_flush_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (hif.pc_stall && (stall_q != {CW{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
      if (hif.ifid_flush && (flush_q != {CW{1'b1}})) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign hif.stall_cnt = stall_q;
  assign hif.flush_cnt = flush_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed plus randomized checks of hazard_ctrl against a cycle-count model
module tb_hazard_ctrl;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs1 = 0, id_uses_rs2 = 0, id_is_mdu = 0;
  logic       ex_mem_read = 0, ex_branch_taken = 0;

  int passed = 0;
  int total  = 0;

  // model state: cycle index, first non-busy cycle, event totals
  longint cyc      = 0;
  longint busy_end = 0;
  longint n_stall  = 0;
  longint n_flush  = 0;

  hazard_ctrl_if #(.CW(32)) if0 ();
  hazard_ctrl_if #(.CW(4))  if1 ();

  assign if0.id_rs1 = id_rs1;           assign if1.id_rs1 = id_rs1;
  assign if0.id_rs2 = id_rs2;           assign if1.id_rs2 = id_rs2;
  assign if0.id_uses_rs1 = id_uses_rs1; assign if1.id_uses_rs1 = id_uses_rs1;
  assign if0.id_uses_rs2 = id_uses_rs2; assign if1.id_uses_rs2 = id_uses_rs2;
  assign if0.id_is_mdu = id_is_mdu;     assign if1.id_is_mdu = id_is_mdu;
  assign if0.ex_rd = ex_rd;             assign if1.ex_rd = ex_rd;
  assign if0.ex_mem_read = ex_mem_read; assign if1.ex_mem_read = ex_mem_read;
  assign if0.ex_branch_taken = ex_branch_taken;
  assign if1.ex_branch_taken = ex_branch_taken;

  hazard_ctrl #(.MDU_LAT(LAT), .CW(32)) u0 (.clk(clk), .rst_n(rst_n), .hif(if0));
  hazard_ctrl #(.MDU_LAT(LAT), .CW(4))  u1 (.clk(clk), .rst_n(rst_n), .hif(if1));

  always #5 clk = ~clk;

  function automatic logic [5:0] ctl0();
    return {if0.pc_stall, if0.ifid_stall, if0.ifid_flush,
            if0.idex_stall, if0.idex_flush, if0.exmem_flush};
  endfunction

  function automatic logic [5:0] ctl1();
    return {if1.pc_stall, if1.ifid_stall, if1.ifid_flush,
            if1.idex_stall, if1.idex_flush, if1.exmem_flush};
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit model_lu();
    return ex_mem_read && ex_rd != 0 &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  endfunction

  // expected {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush}
  function automatic logic [5:0] model_ctl();
    if (!rst_n)              return 6'b000000;
    if (cyc < busy_end)      return 6'b110101;
    if (ex_branch_taken)     return 6'b001010;
    if (model_lu())          return 6'b110010;
    return 6'b000000;
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    busy_end = cyc;
    n_stall  = 0;
    n_flush  = 0;
  endtask

  // Check at negedge with inputs stable, then advance the model across the posedge
  task automatic step(input string tag);
    logic [5:0] e;
    bit issue;
    @(negedge clk);
    e = model_ctl();
    issue = rst_n && !(cyc < busy_end) && !ex_branch_taken && !model_lu() && id_is_mdu;
    check({tag, "_ctl0"}, longint'(ctl0()), longint'(e));
    check({tag, "_ctl1"}, longint'(ctl1()), longint'(e));
    check({tag, "_scnt0"}, longint'(if0.stall_cnt), sat(n_stall, 32));
    check({tag, "_fcnt0"}, longint'(if0.flush_cnt), sat(n_flush, 32));
    check({tag, "_scnt1"}, longint'(if1.stall_cnt), sat(n_stall, 4));
    check({tag, "_fcnt1"}, longint'(if1.flush_cnt), sat(n_flush, 4));
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (e[5]) n_stall++;
      if (e[3]) n_flush++;
      if (issue) busy_end = cyc + LAT;
      cyc++;
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic mdu, input logic [4:0] rd,
                        input logic mr, input logic br);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_is_mdu = mdu; ex_rd = rd; ex_mem_read = mr; ex_branch_taken = br;
  endtask

  initial begin
    // reset held with a load-use pattern on the inputs
    model_reset();
    set_in(5, 0, 1, 0, 0, 5, 1, 0);
    step("rst_a");
    step("rst_b");
    rst_n = 1'b1;
    // load-use then hazard clears
    step("lu");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step("lu_clr");
    check("lu_scnt", longint'(if0.stall_cnt), 64'd1);
    // no-hazard cases
    set_in(0, 0, 1, 0, 0, 0, 1, 0);
    step("rd0");
    set_in(0, 5, 0, 0, 0, 5, 1, 0);
    step("rs2_unused");
    // branch wins over load-use
    set_in(5, 0, 1, 0, 0, 5, 1, 1);
    step("br_pri");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step("br_clr");
    check("br_fcnt", longint'(if0.flush_cnt), 64'd1);
    // MDU pulse; branch during busy is ignored
    set_in(0, 0, 0, 0, 1, 0, 0, 0);
    step("mdu_iss");
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < LAT - 1; i++) step("mdu_busy");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step("mdu_done");
    // reset asserted in the second busy cycle
    set_in(0, 0, 0, 0, 1, 0, 0, 0);
    step("rmdu_iss");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step("rmdu_busy1");
    rst_n = 1'b0;
    #1;
    check("rmdu_async0", longint'(ctl0()), 64'd0);
    check("rmdu_async1", longint'(ctl1()), 64'd0);
    model_reset();
    step("rmdu_inrst");
    rst_n = 1'b1;
    step("rmdu_post");
    // 20 consecutive load-use stalls saturate the 4-bit counter
    set_in(7, 0, 1, 0, 0, 7, 1, 0);
    for (int i = 0; i < 20; i++) step("sat");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("sat_cw4", longint'(if1.stall_cnt), 64'd15);
    check("sat_cw32", longint'(if0.stall_cnt), 64'd20);
    @(posedge clk);
    #1;
    cyc++;
    // randomized traffic over a small register range so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
             5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 7) == 0));
      step("rnd");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
